// File: rtl/factorial_bcd_converter_if.sv
// factorial_bcd_converter_if
// Result-side bus of the factorial BCD converter: the done/dack capture
// handshake from the generator and the valid/ready BCD output.
// The ndigits signal exists only when BCD_DIGIT_COUNT_EN is defined.
interface factorial_bcd_converter_if #(
  parameter int IN_W   = 41,
  parameter int DIGITS = 13
) ();
  logic [IN_W-1:0]     product;
  logic                done;
  logic                dack;
  logic [4*DIGITS-1:0] bcd;
  logic                out_valid;
  logic                out_rdy;
`ifdef BCD_DIGIT_COUNT_EN
  logic [3:0]          ndigits;
`endif

  // Converter side
  modport slave (
    input  product,
    input  done,
    input  out_rdy,
    output dack,
    output bcd,
`ifdef BCD_DIGIT_COUNT_EN
    output ndigits,
`endif
    output out_valid
  );

  // Generator / display side
  modport master (
    output product,
    output done,
    output out_rdy,
    input  dack,
    input  bcd,
`ifdef BCD_DIGIT_COUNT_EN
    input  ndigits,
`endif
    input  out_valid
  );
endinterface

// File: rtl/factorial_bcd_converter.sv
// factorial_bcd_converter
// Captures one binary product over done/dack, converts it to packed BCD with
// a bit-serial shift-and-add-3 engine (one bit per clock), then holds the
// result on a valid/ready output until accepted.
// Optional feature macro: BCD_DIGIT_COUNT_EN adds the ndigits output
// (count of significant digits, minimum 1).
module factorial_bcd_converter #(
  parameter int IN_W   = 41,
  parameter int DIGITS = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  factorial_bcd_converter_if.slave bus
);

  localparam int BCD_W      = 4 * DIGITS;
  localparam int CNT_W      = $clog2(IN_W + 1);
  // ceil(IN_W * log10(2)) using log10(2) ~= 0.30103
  localparam int MIN_DIGITS = (IN_W * 30103 + 99999) / 100000;

  // Reject parameter sets where the largest input cannot be represented
  generate
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("factorial_bcd_converter: DIGITS too small for IN_W");
    end
`ifdef BCD_DIGIT_COUNT_EN
    if (DIGITS > 15) begin : g_ndigits_check
      $error("factorial_bcd_converter: ndigits is 4 bits, DIGITS must be <= 15");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dack_q, dack_d;
  logic             out_valid_q, out_valid_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [IN_W-1:0]  bin_shift;

  // Per-digit add-3 correction; each digit is corrected on its own 4 bits,
  // nothing carries into the neighbour
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) :
                                   bcd_q[4*gi +: 4];
    end
  endgenerate

  // One double-dabble step: binary MSB shifts into BCD bit 0
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
  assign bin_shift = {bin_q[IN_W-2:0], 1'b0};

`ifdef BCD_DIGIT_COUNT_EN
  logic [3:0] ndigits_q, ndigits_d;
  logic [3:0] ndigits_calc;

  // Significant-digit count of the accumulator after the final step
  always_comb begin
    ndigits_calc = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        ndigits_calc = 4'(i + 1);
      end
    end
  end
`endif

  // Next-state logic for the IDLE / CONV / HOLD sequencer
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    dack_d      = 1'b0;
    out_valid_d = out_valid_q;
`ifdef BCD_DIGIT_COUNT_EN
    ndigits_d   = ndigits_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.done) begin
          bin_d   = bus.product;
          bcd_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          dack_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef BCD_DIGIT_COUNT_EN
          ndigits_d   = ndigits_calc;
`endif
        end
      end
      S_HOLD: begin
        // done is deliberately ignored here; a pending capture waits a cycle
        if (bus.out_rdy) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      dack_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BCD_DIGIT_COUNT_EN
      ndigits_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      dack_q      <= dack_d;
      out_valid_q <= out_valid_d;
`ifdef BCD_DIGIT_COUNT_EN
      ndigits_q   <= ndigits_d;
`endif
    end
  end

  assign bus.dack      = dack_q;
  assign bus.bcd       = bcd_q;
  assign bus.out_valid = out_valid_q;
`ifdef BCD_DIGIT_COUNT_EN
  assign bus.ndigits   = ndigits_q;
`endif

endmodule
